instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: local instruction memory, prefetch FIFO and a
// run/drain/halt controller that supports stall and branch redirects.
module instr_fetch_unit #(
    parameter int IMEM_DEPTH = 64,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int PW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic          stall,
    input  logic          redirect_en,
    input  logic [AW-1:0] redirect_pc,
    output logic [31:0]   instruction,
    output logic          instr_valid,
    output logic [AW-1:0] pc_out,
    output logic [1:0]    fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, HALT = 2'b11} state_t;

    state_t        state;
    logic [31:0]   imem      [IMEM_DEPTH];
    logic [31:0]   fifo_word [FIFO_DEPTH];
    logic [AW-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic [AW-1:0] fetch_pc, next_pc;
    logic [31:0]   fetch_word;
    logic          full, empty, redir, push, pop;

    assign fetch_word = imem[fetch_pc];
    assign next_pc    = (fetch_pc == AW'(IMEM_DEPTH - 1)) ? '0 : fetch_pc + AW'(1);
    assign full       = (count == (PW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign redir      = redirect_en && (state == RUN || state == DRAIN);
    // Push/pop decisions use start-of-cycle occupancy; a redirect suppresses both.
    assign push       = (state == RUN) && !full && !redir;
    assign pop        = !stall && !empty && !redir;
    assign fsm_state  = state;

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en)
            imem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= fetch_word;
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else if (redir) begin
            state       <= RUN;
            fetch_pc    <= redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= next_pc;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                instruction <= fifo_word[rd_ptr];
                pc_out      <= fifo_pc[rd_ptr];
                instr_valid <= 1'b1;
            end else if (!stall) begin
                instruction <= '0;
                instr_valid <= 1'b0;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            case (state)
                IDLE, HALT: if (start) begin
                    state    <= RUN;
                    fetch_pc <= '0;
                end
                // The HALT word itself is queued; fetching stops behind it.
                RUN:   if (push && fetch_word[31:28] == 4'hF) state <= DRAIN;
                DRAIN: if (empty && !stall) state <= HALT;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle table for the basic
// program, scoreboard for stall, redirect, wrap and reset sequences.
module tb_instr_fetch_unit;
    logic        clk, reset, load_en, start, stall, redirect_en;
    logic [5:0]  load_addr, redirect_pc, pc_out;
    logic [31:0] load_data, instruction;
    logic        instr_valid;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    int d0;

    typedef struct {
        logic        start, stall, redir;
        logic [5:0]  rpc;
        logic        ev;
        logic [5:0]  epc;
        logic [31:0] ei;
        logic [1:0]  est;
    } vec_t;

    typedef struct {
        logic [5:0]  pc;
        logic [31:0] word;
    } exp_t;

    vec_t        tbl[9];
    exp_t        sbq[$];
    exp_t        last;
    logic [31:0] model[64];

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stall(stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .instruction(instruction), .instr_valid(instr_valid),
        .pc_out(pc_out), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int a, logic [31:0] d);
        load_en = 1'b1;
        load_addr = 6'(a);
        load_data = d;
        model[a] = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic sb_push(int pc);
        exp_t e;
        e.pc = 6'(pc);
        e.word = model[pc];
        sbq.push_back(e);
    endtask

    // A new delivery is a valid output after an edge where stall was low.
    task automatic sb_step();
        logic s;
        exp_t e;
        s = stall;
        tick();
        if (!s && instr_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %0d, expected no delivery", pc_out);
            end else begin
                e = sbq.pop_front();
                chk("sb_pc", 32'(pc_out), 32'(e.pc));
                chk("sb_word", instruction, e.word);
                last = e;
                delivered++;
            end
        end
    endtask

    task automatic drain_sb(string name);
        for (int k = 0; k < 20 && sbq.size() != 0; k++) sb_step();
        chk(name, sbq.size(), 0);
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        tick(); tick();
        chk("rst_instr", instruction, 32'h0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_state", 32'(fsm_state), 0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) load(i, 32'h1000_0000 + 32'(i) * 32'h1001);
        load(0, 32'h1123_0000);
        load(1, 32'h2456_0000);
        load(2, 32'h3780_0000);
        load(3, 32'hF000_0000);

        //       start stall redir rpc  ev epc ei             est
        tbl[0] = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 32'h0,         2'b01};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0, 32'h0,         2'b01};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0, 32'h1123_0000, 2'b01};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd1, 32'h2456_0000, 2'b01};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd2, 32'h3780_0000, 2'b10};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd3, 32'hF000_0000, 2'b10};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd3, 32'h0,         2'b11};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 6'd10, 1'b0, 6'd3, 32'h0,         2'b11};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd3, 32'h0,         2'b11};
        for (int r = 0; r < 9; r++) begin
            start = tbl[r].start; stall = tbl[r].stall;
            redirect_en = tbl[r].redir; redirect_pc = tbl[r].rpc;
            tick();
            chk($sformatf("row%0d_valid", r), 32'(instr_valid), 32'(tbl[r].ev));
            chk($sformatf("row%0d_pc", r), 32'(pc_out), 32'(tbl[r].epc));
            chk($sformatf("row%0d_instr", r), instruction, tbl[r].ei);
            chk($sformatf("row%0d_state", r), 32'(fsm_state), 32'(tbl[r].est));
        end
        redirect_en = 1'b0;

        // Stall with a filling FIFO, then release.
        load(3, 32'h1000_0000 + 32'd3 * 32'h1001);
        sbq.delete();
        for (int i = 0; i < 12; i++) sb_push(i);
        start = 1'b1;
        sb_step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) sb_step();
        chk("pre_stall_count", delivered, 3);
        stall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sb_step();
            chk("stall_pc", 32'(pc_out), 32'(last.pc));
            chk("stall_instr", instruction, last.word);
            chk("stall_valid", 32'(instr_valid), 1);
        end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) sb_step();
        chk("release_count", delivered, 7);

        // Redirect under stall with a full FIFO.
        stall = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        redirect_en = 1'b1; redirect_pc = 6'd10;
        tick();
        chk("redir_valid", 32'(instr_valid), 0);
        chk("redir_instr", instruction, 32'h0);
        chk("redir_state", 32'(fsm_state), 1);
        redirect_en = 1'b0; stall = 1'b0;
        tick();
        chk("redir_r1_valid", 32'(instr_valid), 0);
        tick();
        chk("redir_r2_valid", 32'(instr_valid), 1);
        chk("redir_r2_pc", 32'(pc_out), 10);
        chk("redir_r2_instr", instruction, model[10]);
        sbq.delete();
        sb_push(11); sb_push(12);
        d0 = delivered;
        sb_step(); sb_step();
        chk("redir_follow", delivered, d0 + 2);

        // Wrap from 62; start must be ignored while running.
        redirect_en = 1'b1; redirect_pc = 6'd62;
        tick();
        redirect_en = 1'b0;
        sbq.delete();
        sb_push(62); sb_push(63); sb_push(0); sb_push(1);
        start = 1'b1;
        sb_step();
        start = 1'b0;
        drain_sb("wrap_done");
        chk("wrap_state", 32'(fsm_state), 1);

        // Reset mid-run with a full FIFO; imem must survive.
        stall = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0;
        chk("mrst_state", 32'(fsm_state), 0);
        chk("mrst_instr", instruction, 32'h0);
        chk("mrst_valid", 32'(instr_valid), 0);
        chk("mrst_pc", 32'(pc_out), 0);
        sbq.delete();
        for (int i = 0; i < 6; i++) sb_push(i);
        start = 1'b1;
        sb_step();
        start = 1'b0;
        drain_sb("restart_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
